// File: rtl/bsdeser.sv
// bsdeser: receives LSB-first serial words (data bit + bit-0 sync pulse) and presents them on a valid/ready port.
// Define BSDESER_FIFO2_EN to use a 2-entry output FIFO instead of a single output register.
module bsdeser #(
    parameter int LEN = 94
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           is,
    input  logic           isync,
    output logic [LEN-1:0] q,
    output logic           qvalid,
    input  logic           qready,
    output logic           framerr,
    output logic           overrun
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [LEN-2:0] shreg;
    logic           complete;
    logic [LEN-1:0] word;

    // The final bit is never stored in shreg; it goes straight into the completed word.
    assign complete = (state == RECV) && (cnt == LAST);
    assign word     = {is, shreg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            framerr <= 1'b0;
        end else begin
            framerr <= 1'b0;
            case (state)
                IDLE: begin
                    if (isync) begin
                        shreg[0] <= is;
                        cnt      <= CW'(1);
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (cnt == LAST) begin
                        // cnt=0 in RECV means the next cycle is bit 0 of a word that was already synced
                        cnt   <= '0;
                        state <= isync ? RECV : IDLE;
                    end else if (isync && (cnt != '0)) begin
                        framerr  <= 1'b1;
                        shreg[0] <= is;
                        cnt      <= CW'(1);
                    end else begin
                        shreg[cnt] <= is;
                        cnt        <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BSDESER_FIFO2_EN
    logic [LEN-1:0] tail;
    logic [1:0]     count;
    logic           pop;

    assign qvalid = (count != 2'd0);
    assign pop    = qready && (count != 2'd0);

    // q is the head entry; tail only holds data when two words are buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            tail    <= '0;
            count   <= 2'd0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pop && complete) begin
                if (count == 2'd2) begin
                    q    <= tail;
                    tail <= word;
                end else begin
                    q <= word;
                end
            end else if (pop) begin
                if (count == 2'd2) begin
                    q <= tail;
                end
                count <= count - 2'd1;
            end else if (complete) begin
                if (count == 2'd0) begin
                    q     <= word;
                    count <= 2'd1;
                end else if (count == 2'd1) begin
                    tail  <= word;
                    count <= 2'd2;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            qvalid  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!qvalid || qready) begin
                    q      <= word;
                    qvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (qready) begin
                qvalid <= 1'b0;
            end
        end
    end
`endif

endmodule
